// File: rtl/uart_transmitter_parametric.sv
// uart_transmitter_parametric: FIFO-buffered UART transmitter with configurable
// data width, FIFO depth, baud divisors, runtime parity and stop-bit modes.
//
// Ports:
//   clock                  system clock, rising edge
//   reset                  asynchronous, active-low
//   write_enable, data     push one word into the FIFO
//   buffer_full_threshold  almost-full level (0 = flag only on true full)
//   baudrate_select        picks BAUD_DIV_0..3, latched per frame
//   parity_mode            00/11 none, 01 even, 10 odd, latched per frame
//   stop_bits              0 = one, 1 = two, latched per frame
//   data_out               registered serial line, idle high
//   buffer_full            threshold / full flag
//   buffer_empty           FIFO holds nothing
//   fifo_count             entries stored
//   busy                   a frame is on the line
//   overflow               one-cycle pulse after a dropped write
module uart_transmitter_parametric #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 64,
   parameter int BAUD_DIV_0 = 5208,
   parameter int BAUD_DIV_1 = 2604,
   parameter int BAUD_DIV_2 = 434,
   parameter int BAUD_DIV_3 = 16,
   localparam int AW = $clog2(FIFO_DEPTH)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  write_enable,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [AW-1:0]         buffer_full_threshold,
   input  logic [1:0]            baudrate_select,
   input  logic [1:0]            parity_mode,
   input  logic                  stop_bits,
   output logic                  data_out,
   output logic                  buffer_full,
   output logic                  buffer_empty,
   output logic [AW:0]           fifo_count,
   output logic                  busy,
   output logic                  overflow
);

   localparam int MAX_01 = BAUD_DIV_0 > BAUD_DIV_1 ? BAUD_DIV_0 : BAUD_DIV_1;
   localparam int MAX_23 = BAUD_DIV_2 > BAUD_DIV_3 ? BAUD_DIV_2 : BAUD_DIV_3;
   localparam int MAX_DIV = MAX_01 > MAX_23 ? MAX_01 : MAX_23;
   // The divisor is stored minus one, so the widest value is MAX_DIV-1.
   localparam int CW = $clog2(MAX_DIV);
   localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [AW:0]           r_count;
   logic                  r_overflow;
   logic                  r_data_out;
   state_t                r_state;
   state_t                w_next_state;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [CW-1:0]         r_baud_cnt;
   logic [CW-1:0]         r_div_m1;
   logic [CW-1:0]         w_sel_div_m1;
   logic [3:0]            r_bit_idx;
   logic                  r_par_en;
   logic                  r_par_bit;
   logic                  r_stop2;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_empty;
   logic                  w_bit_end;
   logic                  w_last_stop;
   logic                  w_data_out_next;
   logic [DATA_WIDTH-1:0] w_head;

   // Acceptance looks only at the pre-edge count, so a write at full is
   // dropped even when a pop happens on the same edge.
   assign w_empty     = r_count == '0;
   assign w_push      = write_enable && (r_count != FULL_C);
   assign w_head      = r_mem[r_rd_ptr];
   assign w_bit_end   = r_baud_cnt == r_div_m1;
   assign w_last_stop = r_bit_idx == {3'b000, r_stop2};

   assign w_sel_div_m1 = baudrate_select == 2'd0 ? CW'(BAUD_DIV_0 - 1) :
                         baudrate_select == 2'd1 ? CW'(BAUD_DIV_1 - 1) :
                         baudrate_select == 2'd2 ? CW'(BAUD_DIV_2 - 1) :
                                                   CW'(BAUD_DIV_3 - 1);

   assign data_out     = r_data_out;
   assign buffer_empty = w_empty;
   assign fifo_count   = r_count;
   assign busy         = r_state != IDLE;
   assign overflow     = r_overflow;
   assign buffer_full  = (r_count == FULL_C) ||
                         ((buffer_full_threshold != '0) && (r_count >= {1'b0, buffer_full_threshold}));

   // Storage has no reset; discarding contents is done through the pointers.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= data;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count    <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
         r_overflow <= write_enable && !w_push;
      end
   end

   // FSM state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else r_state <= w_next_state;
   end

   // FSM next-state logic
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE:    if (!w_empty) w_next_state = START;
         START:   if (w_bit_end) w_next_state = DATA;
         DATA:    if (w_bit_end && r_bit_idx == LAST_BIT) w_next_state = r_par_en ? PARITY : STOP;
         PARITY:  if (w_bit_end) w_next_state = STOP;
         STOP:    if (w_bit_end && w_last_stop) w_next_state = w_empty ? IDLE : START;
         default: w_next_state = IDLE;
      endcase
   end

   // FSM outputs: the pop strobe and the value the line register takes next.
   // Inside DATA the bit about to be sent is shift[1] when the shift happens
   // on this edge, otherwise shift[0].
   always_comb begin
      w_pop = !w_empty && (r_state == IDLE || (r_state == STOP && w_bit_end && w_last_stop));
      w_data_out_next = 1'b1;
      unique case (w_next_state)
         START:   w_data_out_next = 1'b0;
         DATA:    w_data_out_next = (r_state == DATA && w_bit_end) ? r_shift[1] : r_shift[0];
         PARITY:  w_data_out_next = r_par_bit;
         default: w_data_out_next = 1'b1;
      endcase
   end

   // Datapath: frame configuration is captured together with the popped word.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_data_out <= 1'b1;
         r_shift    <= '0;
         r_baud_cnt <= '0;
         r_div_m1   <= '0;
         r_bit_idx  <= '0;
         r_par_en   <= 1'b0;
         r_par_bit  <= 1'b0;
         r_stop2    <= 1'b0;
      end else begin
         r_data_out <= w_data_out_next;
         if (w_pop) begin
            r_shift    <= w_head;
            r_par_bit  <= (^w_head) ^ (parity_mode == 2'b10);
            r_par_en   <= ^parity_mode;
            r_stop2    <= stop_bits;
            r_div_m1   <= w_sel_div_m1;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
         end else begin
            r_baud_cnt <= (r_state == IDLE || w_bit_end) ? '0 : r_baud_cnt + 1'b1;
            r_bit_idx  <= (w_next_state != r_state) ? '0 : r_bit_idx + 4'(w_bit_end);
            if (r_state == DATA && w_bit_end) r_shift <= r_shift >> 1;
         end
      end
   end

endmodule

// File: tb/tb_uart_transmitter_parametric.sv
// tb_uart_transmitter_parametric: directed self-checking bench for uart_transmitter_parametric.
module tb_uart_transmitter_parametric;

   logic       clock;
   logic       reset;
   logic       write_enable;
   logic [7:0] data;
   logic [5:0] buffer_full_threshold;
   logic [1:0] baudrate_select;
   logic [1:0] parity_mode;
   logic       stop_bits;
   logic       data_out;
   logic       buffer_full;
   logic       buffer_empty;
   logic [6:0] fifo_count;
   logic       busy;
   logic       overflow;

   int errors = 0;
   int checks = 0;

   uart_transmitter_parametric dut (
      .clock(clock),
      .reset(reset),
      .write_enable(write_enable),
      .data(data),
      .buffer_full_threshold(buffer_full_threshold),
      .baudrate_select(baudrate_select),
      .parity_mode(parity_mode),
      .stop_bits(stop_bits),
      .data_out(data_out),
      .buffer_full(buffer_full),
      .buffer_empty(buffer_empty),
      .fifo_count(fifo_count),
      .busy(busy),
      .overflow(overflow)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic push(input logic [7:0] d);
      write_enable = 1'b1;
      data = d;
      step(1);
      write_enable = 1'b0;
   endtask

   // Expects to be called at the first falling clock of the start bit (or
   // skip cycles into it); checks the first and last cycle of every bit.
   task automatic frame(input int div, input logic [7:0] d, input logic [1:0] pm,
                        input logic s2, input int skip, input string tag);
      logic [15:0] b;
      int n;
      int w;
      b = '1;
      b[0] = 1'b0;
      for (int i = 0; i < 8; i++) b[i+1] = d[i];
      n = 10;
      if (pm == 2'b01 || pm == 2'b10) begin
         b[9] = (^d) ^ (pm == 2'b10);
         n = 11;
      end
      if (s2) n++;
      for (int j = 0; j < n; j++) begin
         w = (j == 0) ? skip : 0;
         if (w == 0) chk($sformatf("%s_bit%0d_first", tag, j), data_out, b[j]);
         step(div - 1 - w);
         chk($sformatf("%s_bit%0d_last", tag, j), data_out, b[j]);
         step(1);
      end
   endtask

   initial begin
      int t;
      reset = 1'b0;
      write_enable = 1'b0;
      data = '0;
      buffer_full_threshold = '0;
      baudrate_select = 2'd0;
      parity_mode = 2'b00;
      stop_bits = 1'b0;
      step(3);
      chk("rst_data_out", data_out, 1);
      chk("rst_empty", buffer_empty, 1);
      chk("rst_full", buffer_full, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overflow", overflow, 0);
      reset = 1'b1;
      step(100);
      chk("idle_data_out", data_out, 1);
      chk("idle_busy", busy, 0);
      chk("idle_count", fifo_count, 0);
      chk("idle_empty", buffer_empty, 1);

      // single frame 0xA5, 16 cycles per bit
      baudrate_select = 2'd3;
      push(8'hA5);
      chk("a5_count_push", fifo_count, 1);
      chk("a5_line_before", data_out, 1);
      chk("a5_busy_before", busy, 0);
      step(1);
      chk("a5_busy_start", busy, 1);
      chk("a5_count_pop", fifo_count, 0);
      chk("a5_empty_pop", buffer_empty, 1);
      frame(16, 8'hA5, 2'b00, 1'b0, 0, "a5");
      chk("a5_busy_after", busy, 0);
      chk("a5_line_after", data_out, 1);

      // even parity with two stop bits, then odd parity with one
      parity_mode = 2'b01;
      stop_bits = 1'b1;
      push(8'h07);
      step(1);
      frame(16, 8'h07, 2'b01, 1'b1, 0, "p07");
      chk("p07_busy_after", busy, 0);
      parity_mode = 2'b10;
      stop_bits = 1'b0;
      push(8'h03);
      step(1);
      frame(16, 8'h03, 2'b10, 1'b0, 0, "p03");
      chk("p03_busy_after", busy, 0);

      // back-to-back frames
      parity_mode = 2'b00;
      write_enable = 1'b1;
      data = 8'h00;
      step(1);
      chk("b2b_count1", fifo_count, 1);
      data = 8'hFF;
      step(1);
      chk("b2b_count2", fifo_count, 1);
      chk("b2b_start", data_out, 0);
      data = 8'h55;
      step(1);
      write_enable = 1'b0;
      chk("b2b_peak", fifo_count, 2);
      frame(16, 8'h00, 2'b00, 1'b0, 1, "b2b00");
      chk("b2b_count_ff", fifo_count, 1);
      chk("b2b_empty_ff", buffer_empty, 0);
      frame(16, 8'hFF, 2'b00, 1'b0, 0, "b2bff");
      chk("b2b_count_55", fifo_count, 0);
      chk("b2b_empty_55", buffer_empty, 1);
      frame(16, 8'h55, 2'b00, 1'b0, 0, "b2b55");
      chk("b2b_busy_after", busy, 0);

      // fill to full with a frame in flight, then overflow
      buffer_full_threshold = 6'd10;
      push(8'hC3);
      for (int k = 1; k <= 65; k++) begin
         write_enable = 1'b1;
         data = 8'(k);
         step(1);
         chk($sformatf("fill%0d_count", k), fifo_count, (k > 64) ? 64 : k);
         chk($sformatf("fill%0d_full", k), buffer_full, (k >= 10) ? 1 : 0);
         chk($sformatf("fill%0d_overflow", k), overflow, (k == 65) ? 1 : 0);
      end
      write_enable = 1'b0;
      buffer_full_threshold = '0;
      step(1);
      chk("ovf_pulse_end", overflow, 0);
      chk("thr0_full_at_64", buffer_full, 1);
      chk("thr0_count", fifo_count, 64);
      t = 0;
      while (fifo_count !== 7'd63 && t < 400) begin
         step(1);
         t++;
      end
      chk("drain_first_pop_timeout", (t < 400) ? 1 : 0, 1);
      chk("thr0_full_at_63", buffer_full, 0);
      for (int k = 1; k <= 64; k++) frame(16, 8'(k), 2'b00, 1'b0, 0, $sformatf("drain%0d", k));
      chk("drain_busy", busy, 0);
      chk("drain_empty", buffer_empty, 1);
      step(200);
      chk("drain_no_65th_line", data_out, 1);
      chk("drain_no_65th_busy", busy, 0);

      // divisor change mid-frame takes effect on the next frame
      baudrate_select = 2'd3;
      push(8'h5A);
      step(1);
      baudrate_select = 2'd2;
      write_enable = 1'b1;
      data = 8'h81;
      step(1);
      write_enable = 1'b0;
      frame(16, 8'h5A, 2'b00, 1'b0, 1, "cfg5a");
      frame(434, 8'h81, 2'b00, 1'b0, 0, "cfg81");
      chk("cfg_busy_after", busy, 0);

      // asynchronous reset in the middle of a stop bit
      baudrate_select = 2'd3;
      push(8'h3C);
      push(8'h11);
      step(16 * 9 + 5);
      chk("arst_pre_count", fifo_count, 1);
      chk("arst_pre_busy", busy, 1);
      #2 reset = 1'b0;
      #1;
      chk("arst_data_out", data_out, 1);
      chk("arst_count", fifo_count, 0);
      chk("arst_busy", busy, 0);
      chk("arst_empty", buffer_empty, 1);
      chk("arst_full", buffer_full, 0);
      chk("arst_overflow", overflow, 0);
      step(1);
      reset = 1'b1;
      step(40);
      chk("arst_discard_line", data_out, 1);
      chk("arst_discard_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_transmitter_parametric.md
# uart_transmitter_parametric

Parametrised successor to the fixed 8-bit UART transmitter. It provides a configurable data width, FIFO depth and per-select baud divisors. It adds runtime parity and stop-bit modes, FIFO status outputs and overflow reporting. It sits between the bus-side write port and the serial line. Every frame is built from FIFO contents, and the frame configuration is latched at start of frame.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal 5..9
- FIFO_DEPTH, 64, FIFO entries; power of two, 4..256; AW = $clog2(FIFO_DEPTH)
- BAUD_DIV_0 / _1 / _2 / _3, 5208 / 2604 / 434 / 16, clock cycles per bit for baudrate_select 0..3; each ≥ 2
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low
- write_enable  input  1  push data into FIFO on this rising edge
- data  input  DATA_WIDTH  word to push
- buffer_full_threshold  input  AW  almost-full level; 0 = flag only on true full
- baudrate_select  input  2  selects BAUD_DIV_n
- parity_mode  input  2  00 none, 01 even, 10 odd, 11 none
- stop_bits  input  1  0 = one stop bit, 1 = two
- data_out  output  1  serial line, idle high
- buffer_full  output  1  threshold flag (see Operation)
- buffer_empty  output  1  FIFO count == 0
- fifo_count  output  AW+1  entries currently stored
- busy  output  1  FSM not in IDLE
- overflow  output  1  one-cycle pulse, write dropped

## Operation
- FIFO:
  - Circular buffer with wrapping read/write pointers and a registered count.
  - A write is accepted when the pre-edge count < FIFO_DEPTH. This holds even if a pop occurs on the same edge.
  - A write at full is dropped and overflow pulses for 1 cycle.
  - A simultaneous accepted write and pop leaves count unchanged.
- buffer_full:
  - Combinational.
  - When threshold ≠ 0: buffer_full = (count ≥ threshold) OR (count == FIFO_DEPTH).
  - When threshold == 0: buffer_full = (count == FIFO_DEPTH).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - data_out = 1.
  - If the FIFO is non-empty, pop the head into the shift register.
  - Latch the divisor, parity_mode and stop_bits, then go to START.
  - Config changes mid-frame have no effect until the next frame.
- START: data_out = 0 for one bit time.
- DATA: DATA_WIDTH bits, LSB first, one bit time each.
- PARITY:
  - Present only when the latched mode is 01 or 10.
  - Even mode sends the XOR of the data bits; odd mode sends its inverse.
  - If parity is disabled, the FSM skips this state.
- STOP:
  - data_out = 1 for 1 or 2 bit times.
  - At the end, if the FIFO is non-empty, pop and go directly to START with no idle cycle. Otherwise go to IDLE.
- Bit timing: a counter runs 0..DIV-1 and the bit advances when it reaches DIV-1. Each bit lasts exactly DIV cycles.
- Frame length = (1 + DATA_WIDTH + P + S) × DIV cycles, where P ∈ {0,1} and S ∈ {1,2}.
- busy is high in START, DATA, PARITY and STOP.

## Timing
- Reset (async assert, any state, including mid-frame):
  - data_out = 1, buffer_empty = 1.
  - buffer_full = 0, fifo_count = 0, busy = 0, overflow = 0.
  - FSM returns to IDLE and FIFO contents are discarded.
- The first write after idle is counted at edge N.
- At edge N+1 the FSM pops the entry and data_out falls, starting the start bit, and busy rises.
- fifo_count reflects both the push at N and the pop at N+1.
- The start-bit falling edge of a queued frame occurs exactly one bit time after the last stop-bit period begins (S=1), or two bit times after (S=2).
- The serial output is registered, so data_out never glitches.

## Test plan
- Reset and idle: with DIV sel 0 and no writes for 100 cycles, outputs hold their reset values and data_out stays 1. An async reset mid-STOP bit forces data_out = 1 and fifo_count = 0 immediately.
- Single frame:
  - Setup: DATA_WIDTH=8, BAUD_DIV_3=16, sel 3, no parity, 1 stop.
  - Stimulus: write 0xA5.
  - Required: data_out falls 1 cycle later, then bits 1,0,1,0,0,1,0,1 then 1, each 16 cycles; frame = 160 cycles; busy then drops.
- Parity and stop:
  - Setup: parity 01 with 2 stop bits.
  - Stimulus: write 0x07, then 0x03 with parity 10.
  - Required: 0x07 sends parity bit 1 then two stop bits (frame 12×16 = 192 cycles). 0x03 sends parity bit 1.
- Back-to-back: write 0x00, 0xFF and 0x55 on consecutive cycles. The three frames are contiguous with no idle gap, fifo_count peaks at 2 and buffer_empty rises after the third pop.
- Full / threshold / overflow:
  - Setup: threshold 10 with the line busy.
  - Stimulus: write 65 words.
  - Required: buffer_full rises when count reaches 10; count saturates at 64; the 65th write pulses overflow and is never transmitted.
  - Then set threshold 0: buffer_full stays high only while count == 64.
- Config latch: changing baudrate_select from 3 to 2 mid-frame leaves the current frame at 16 cycles/bit. The next frame uses BAUD_DIV_2.
